// File: rtl/cnt_pkg.sv
// Shared constants and types for the counter command arbiter.
package cnt_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] RUN_STOP_DFLT = 16'hFFFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_LOCK = 2'b10
    } state_t;

    function automatic logic [1:0] count_req(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage

// File: rtl/cnt_req_sync.sv
// Previous-level register and rising-edge detect for one requester.
module cnt_req_sync (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic rise
);

    logic prev;

    // Reset to 1 so a level held through reset never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= req;
    end

    assign rise = req & ~prev;

endmodule

// File: rtl/cnt_cmd_arbiter.sv
// Command arbiter for the up/down/load counter: one registered command per clock.
// Optional auto-repeat of held up/down buttons is enabled with CNT_AUTOREPEAT_EN.
module cnt_cmd_arbiter
    import cnt_pkg::*;
#(
    parameter int             W        = CNT_W,
    parameter logic [W-1:0]   RUN_STOP = RUN_STOP_DFLT
`ifdef CNT_AUTOREPEAT_EN
   ,parameter int             REPEAT_DELAY = 8,
    parameter int             REPEAT_RATE  = 4
`endif
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         up_req_i,
    input  logic         dw_req_i,
    input  logic         ld_req_i,
    input  logic         run_i,
    input  logic [W-1:0] din_i,
    input  logic [W-1:0] count_i,
    output logic         up_o,
    output logic         dw_o,
    output logic         ld_o,
    output logic [W-1:0] ld_data_o,
    output logic [1:0]   state_o
);

    logic rise_up, rise_dw, rise_ld;
    logic rep_up, rep_dw;
    logic [1:0] nreq;
    logic run_ok;
    logic edge_up, edge_dw, edge_ld;
    state_t state;

    cnt_req_sync u_up_sync (.clk(clk_i), .rst(rst_i), .req(up_req_i), .rise(rise_up));
    cnt_req_sync u_dw_sync (.clk(clk_i), .rst(rst_i), .req(dw_req_i), .rise(rise_dw));
    cnt_req_sync u_ld_sync (.clk(clk_i), .rst(rst_i), .req(ld_req_i), .rise(rise_ld));

    assign nreq    = count_req(up_req_i, dw_req_i, ld_req_i);
    assign state_o = state;

    // Count the up already in flight so run settles exactly on the ceiling.
    assign run_ok = ({1'b0, count_i} + {{W{1'b0}}, up_o}) < {1'b0, RUN_STOP};

    // Load wins over down wins over up; only one can rise while nreq < 2.
    assign edge_ld = rise_ld;
    assign edge_dw = ~rise_ld & (rise_dw | rep_dw);
    assign edge_up = ~rise_ld & ~edge_dw & (rise_up | rep_up);

`ifdef CNT_AUTOREPEAT_EN
    logic [7:0] timer;
    logic [1:0] prev_nreq;
    logic       armed;
    logic       hold_ok;
    logic       rep_fire;

    assign hold_ok  = (state == ST_IDLE) && (nreq == 2'd1) && (nreq == prev_nreq)
                      && (up_req_i | dw_req_i);
    assign rep_fire = armed && hold_ok && (timer == 8'(REPEAT_DELAY - 1));
    assign rep_up   = rep_fire & up_req_i;
    assign rep_dw   = rep_fire & dw_req_i;

    // Armed only by an edge command, so a level held through reset never repeats.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer     <= '0;
            prev_nreq <= 2'd3;
            armed     <= 1'b0;
        end else begin
            prev_nreq <= nreq;
            if (!hold_ok) begin
                timer <= '0;
                armed <= (state == ST_IDLE) && (nreq == 2'd1) && (rise_up | rise_dw);
            end else if (armed) begin
                if (rep_fire) timer <= 8'(REPEAT_DELAY - REPEAT_RATE);
                else          timer <= timer + 8'd1;
            end
        end
    end
`else
    assign rep_up = 1'b0;
    assign rep_dw = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            up_o      <= 1'b0;
            dw_o      <= 1'b0;
            ld_o      <= 1'b0;
            ld_data_o <= '0;
        end else begin
            up_o <= 1'b0;
            dw_o <= 1'b0;
            ld_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (nreq >= 2'd2) begin
                        state <= ST_LOCK;
                    end else if (edge_ld | edge_dw | edge_up) begin
                        ld_o <= edge_ld;
                        dw_o <= edge_dw;
                        up_o <= edge_up;
                        if (edge_ld) ld_data_o <= din_i;
                    end else if (run_i && nreq == 2'd0) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (nreq >= 2'd2) begin
                        state <= ST_LOCK;
                    end else if (!run_i || nreq != 2'd0) begin
                        state <= ST_IDLE;
                        ld_o  <= edge_ld;
                        dw_o  <= edge_dw;
                        up_o  <= edge_up;
                        if (edge_ld) ld_data_o <= din_i;
                    end else begin
                        up_o <= run_ok;
                    end
                end
                ST_LOCK: begin
                    if (nreq == 2'd0) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cnt_cmd_arbiter.md
Name: cnt_cmd_arbiter

Overview:
- Command controller for the 16-bit loadable up/down counter datapath.
- Arbitrates between raw requester levels (up, down, load button; continuous-run switch) and issues at most one registered one-cycle command per clock: up, down or load.
- Enforces mutual exclusion with a lockout state and stops continuous run exactly at a programmable ceiling.
- Sits between the debounced button/switch inputs and the counter's up/dw/ld/din inputs; takes the counter's q as feedback.

Parameters:
- W, 16, counter/data width.
- RUN_STOP, 16'hFFFC, ceiling at which continuous run stops issuing up.
- REPEAT_DELAY, 8, hold cycles before auto-repeat starts (optional feature only).
- REPEAT_RATE, 4, cycles between auto-repeat pulses (optional feature only).

Ports:
- clk_i  input  1  system clock; single clock domain.
- rst_i  input  1  synchronous, active-high reset.
- up_req_i  input  1  up button level.
- dw_req_i  input  1  down button level.
- ld_req_i  input  1  load button level.
- run_i  input  1  continuous-run level.
- din_i  input  W  load value (switches).
- count_i  input  W  counter q feedback.
- up_o  output  1  counter up command, registered.
- dw_o  output  1  counter down command, registered.
- ld_o  output  1  counter load command, registered.
- ld_data_o  output  W  load data, registered; valid when ld_o=1.
- state_o  output  2  current FSM state (00 IDLE, 01 RUN, 10 LOCK).

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - up_o, dw_o, ld_o = 0; ld_data_o = 0; state = IDLE.
  - Previous-level registers for up/dw/ld load 1, so a button held through reset gives no edge afterwards.
  - Reset mid-RUN or mid-LOCK aborts immediately; no further commands.
- Edges: rise_x = req_x & ~prev_x, where prev_x is the registered level.
- Latency: a command appears on the clock edge after the one that samples the rising input. It is high for exactly one cycle, except in RUN.
- At most one of up_o/dw_o/ld_o is high in any cycle (invariant).
- Requests: nreq = count of up/dw/ld levels high.
- IDLE:
  - nreq>=2: go to LOCK; issue nothing.
  - Else a single rising edge issues its command: ld_o with ld_data_o<=din_i; or dw_o; or up_o.
  - Else run_i=1 and nreq=0: go to RUN.
- RUN:
  - up_o_next = ((count_i + up_o) < RUN_STOP), using a W+1-bit compare. This accounts for the one up still in flight, so the counter settles exactly at RUN_STOP.
  - Count already >= RUN_STOP: up_o stays 0 and state remains RUN.
  - run_i=0 or nreq>=1: go to IDLE with up_o_next=0. A single rising edge in that same cycle is still issued as its command. nreq>=2 goes to LOCK instead.
- LOCK:
  - No commands issued.
  - Exit to IDLE only after one cycle with nreq=0.
  - run_i is ignored while in LOCK.
- Wrap-around (down at 0, up at FFFF) is passed through unmodified; the counter owns wrap behaviour.
- Loading in IDLE while run_i=1 is allowed. RUN resumes from the loaded value on the next cycle with nreq=0.

Optional Feature:
- Macro: CNT_AUTOREPEAT_EN.
- Defined:
  - A single up or down level held in IDLE for REPEAT_DELAY cycles after its edge command re-issues that command every REPEAT_RATE cycles until release.
  - Uses an 8-bit hold timer, reset to 0 on rst_i, on release, or on any nreq change.
  - Load never repeats.
- Undefined:
  - Only edges issue commands.
  - Timer logic is absent, and REPEAT_DELAY/REPEAT_RATE are unused.

Decomposition:
- Shared package cnt_pkg:
  - state encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_LOCK=2'b10.
  - default RUN_STOP.
  - width constant CNT_W=16.
- One sub-module, cnt_req_sync:
  - per-request previous-level register plus rise detect.
  - reset-to-1 behaviour.
  - Instantiated three times.
- FSM and command registers stay in the top module.

Test Plan:
- Reset with up_req_i held high, release reset -> no up_o pulse. Then release and press up -> exactly one up_o pulse, one cycle after the edge.
- din_i=16'hABCD, pulse ld_req_i -> ld_o=1 for one cycle, with ld_data_o=16'hABCD in the same cycle. dw_o and up_o stay 0.
- Press up and down in the same cycle -> state_o=10, no commands. Release only down -> still LOCK. Release both -> IDLE after one cycle, and no command is issued on release.
- Counter model at 16'hFFF0, run_i=1 -> up_o high for exactly 12 consecutive cycles. Counter ends at 16'hFFFC, state_o stays 01, up_o=0 thereafter.
- In RUN at count 16'h0100, press dw_req_i -> one dw_o pulse, no up_o in that cycle, state_o=00. Release -> RUN resumes on the next cycle.
- With CNT_AUTOREPEAT_EN, hold up for 20 cycles with DELAY=8, RATE=4 -> initial pulse, then repeat pulses at edge+8, +12, +16, +20. Without the macro -> single pulse only.
